// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle control unit and its datapath:
// state encoding, opcode/funct constants, ALU control codes and mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU control decode: funct-driven op in R_EXEC, subtract in BRANCH,
// add everywhere else. Also flags whether funct is a supported R-type op.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctl,
  output logic       o_funct_legal
);

  logic [3:0] w_fn_ctl;

  // Map the R-type funct field onto an ALU operation.
  always_comb begin
    w_fn_ctl      = ALU_ADD;
    o_funct_legal = 1'b1;
    case (i_funct)
      FN_ADD:  w_fn_ctl = ALU_ADD;
      FN_SUB:  w_fn_ctl = ALU_SUB;
      FN_AND:  w_fn_ctl = ALU_AND;
      FN_OR:   w_fn_ctl = ALU_OR;
      FN_SLT:  w_fn_ctl = ALU_SLT;
      default: o_funct_legal = 1'b0;
    endcase
  end

  // Choose the ALU operation for the current state.
  always_comb begin
    o_alu_ctl = ALU_ADD;
    if (i_state == S_R_EXEC)      o_alu_ctl = w_fn_ctl;
    else if (i_state == S_BRANCH) o_alu_ctl = ALU_SUB;
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch, decode, execute, memory, write-back
// over a shared memory with a mem_ready handshake.
// Handshake: a memory access is presented by holding mem_read/mem_write and
// its address select stable; it completes in the cycle mem_ready is sampled
// high, and the FSM waits in place (outputs unchanged) while it is low.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_ctl,
  output logic       retired,
  output logic       illegal,
  output logic [3:0] dbg_state
);

  state_t r_state;
  state_t w_next;
  logic   r_run;
  logic   w_active;
  logic   w_funct_legal;
  logic   w_pc_en, w_mem_read, w_mem_write, w_ir_write;
  logic   w_reg_write, w_retired, w_illegal;

  // r_run stays low until the first rising edge after reset release, so the
  // first live FETCH cycle starts on that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // State register, held in FETCH until the FSM is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_state <= S_FETCH;
    else if (r_run) r_state <= w_next;
  end

  mips_alu_decoder u_alu_dec (
    .i_state       (r_state),
    .i_funct       (funct),
    .o_alu_ctl     (alu_ctl),
    .o_funct_legal (w_funct_legal)
  );

  // Next-state and per-state Moore outputs (beq pc_en follows zero).
  always_comb begin
    w_next      = r_state;
    w_pc_en     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_retired   = 1'b0;
    w_illegal   = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    pc_source   = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = SRCB_FOUR;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_en    = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        w_next    = S_FETCH;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE: begin
            if (w_funct_legal) w_next = S_R_EXEC;
            else               w_illegal = 1'b1;
          end
          OP_BEQ:  w_next = S_BRANCH;
          OP_ADDI: w_next = S_ADDI_EXEC;
          OP_J:    w_next = S_JUMP;
          default: w_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord       = 1'b1;
        w_mem_read = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
        w_retired   = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEM_WR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_retired = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
        w_retired   = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALUOUT;
        w_pc_en   = zero;
        w_retired = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        w_next    = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_reg_write = 1'b1;
        w_retired   = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        w_pc_en   = 1'b1;
        w_retired = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset low drops every enable/strobe combinationally, including a write
  // already in flight.
  assign w_active  = reset & r_run;
  assign pc_en     = w_pc_en     & w_active;
  assign mem_read  = w_mem_read  & w_active;
  assign mem_write = w_mem_write & w_active;
  assign ir_write  = w_ir_write  & w_active;
  assign reg_write = w_reg_write & w_active;
  assign retired   = w_retired   & w_active;
  assign illegal   = w_illegal   & w_active;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: an instruction-level reference model
// predicts the state path and per-instruction strobe summary; a monitor
// compares them as the DUT retires or flags each instruction.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, retired, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_ctl, dbg_state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_ctl(alu_ctl),
    .retired(retired), .illegal(illegal), .dbg_state(dbg_state)
  );

  // Expected per-instruction summary.
  typedef struct packed {
    logic       ill;
    logic [7:0] cyc;
    logic [1:0] rw;
    logic       rdst;
    logic       m2r;
    logic [3:0] mwc;
    logic [3:0] mrc;
    logic [3:0] iordc;
    logic [1:0] pcen;
    logic [1:0] pcsrc;
    logic [1:0] irw;
    logic [3:0] aluc;
  } rec_t;
  localparam int W = $bits(rec_t);

  logic [W-1:0] exp_q[$];
  logic [3:0]   st_q[$];
  int           total = 0;
  int           bad = 0;
  logic         mon_en = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_strobes_zero(input string tag);
    chk({tag, "_pc_en"}, pc_en, 0);
    chk({tag, "_ir_write"}, ir_write, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_reg_write"}, reg_write, 0);
    chk({tag, "_retired"}, retired, 0);
    chk({tag, "_illegal"}, illegal, 0);
  endtask

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] fn_to_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      default: return 4'b0111;
    endcase
  endfunction

  // Hold the instruction fields for one clock cycle.
  task automatic drive_cycle(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic rdy);
    @(posedge clk);
    #1;
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = rdy;
  endtask

  // Reference model: derive state path, mem_ready pattern and strobe summary
  // from the instruction, then drive it.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw);
    rec_t       e;
    logic [3:0] seq[$];
    logic       rdy[$];
    logic       fn_ok;
    fn_ok   = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    e       = '0;
    e.aluc  = 4'hF;
    e.irw   = 2'd1;
    e.pcen  = 2'd1;
    e.mrc   = 4'(fw + 1);
    for (int i = 0; i < fw; i++) begin seq.push_back(4'd0); rdy.push_back(1'b0); end
    seq.push_back(4'd0); rdy.push_back(1'b1);
    seq.push_back(4'd1); rdy.push_back(coin());
    case (op)
      6'h23: begin
        seq.push_back(4'd2); rdy.push_back(coin());
        for (int i = 0; i < mw; i++) begin seq.push_back(4'd3); rdy.push_back(1'b0); end
        seq.push_back(4'd3); rdy.push_back(1'b1);
        seq.push_back(4'd4); rdy.push_back(coin());
        e.rw = 2'd1; e.m2r = 1'b1;
        e.mrc = 4'(fw + 1 + mw + 1);
        e.iordc = 4'(mw + 1);
      end
      6'h2B: begin
        seq.push_back(4'd2); rdy.push_back(coin());
        for (int i = 0; i < mw; i++) begin seq.push_back(4'd5); rdy.push_back(1'b0); end
        seq.push_back(4'd5); rdy.push_back(1'b1);
        e.mwc = 4'(mw + 1);
        e.iordc = 4'(mw + 1);
      end
      6'h00: begin
        if (fn_ok) begin
          seq.push_back(4'd6); rdy.push_back(coin());
          seq.push_back(4'd7); rdy.push_back(coin());
          e.rw = 2'd1; e.rdst = 1'b1;
          e.aluc = fn_to_alu(fn);
        end else begin
          e.ill = 1'b1;
        end
      end
      6'h04: begin
        seq.push_back(4'd8); rdy.push_back(coin());
        e.aluc = 4'b0110;
        if (z) begin e.pcen = 2'd2; e.pcsrc = 2'd1; end
      end
      6'h08: begin
        seq.push_back(4'd9); rdy.push_back(coin());
        seq.push_back(4'd10); rdy.push_back(coin());
        e.rw = 2'd1;
      end
      6'h02: begin
        seq.push_back(4'd11); rdy.push_back(coin());
        e.pcen = 2'd2; e.pcsrc = 2'd2;
      end
      default: e.ill = 1'b1;
    endcase
    e.cyc = 8'(seq.size());
    exp_q.push_back(e);
    foreach (seq[k]) st_q.push_back(seq[k]);
    for (int k = 0; k < rdy.size(); k++) drive_cycle(op, fn, z, rdy[k]);
  endtask

  // Monitor: per-cycle state check, per-instruction summary on retire/illegal.
  initial begin
    int         cyc, rw, rdst, m2r, mwc, mrc, iordc, pcen, pcsrc, irw, aluc;
    rec_t       e;
    logic [3:0] es;
    cyc = 0; rw = 0; rdst = 0; m2r = 0; mwc = 0; mrc = 0;
    iordc = 0; pcen = 0; pcsrc = 0; irw = 0; aluc = 15;
    forever begin
      @(negedge clk);
      if (!reset || !mon_en) begin
        cyc = 0; rw = 0; rdst = 0; m2r = 0; mwc = 0; mrc = 0;
        iordc = 0; pcen = 0; pcsrc = 0; irw = 0; aluc = 15;
      end else begin
        if (st_q.size() == 0) begin
          total++; bad++;
          $display("FAIL state_underflow actual=%0d expected=none at %0t", dbg_state, $time);
        end else begin
          es = st_q.pop_front();
          chk("state", dbg_state, es);
        end
        cyc++;
        if (reg_write) begin rw++; rdst = reg_dst; m2r = mem_to_reg; end
        if (mem_write) mwc++;
        if (mem_read) mrc++;
        if ((mem_read || mem_write) && iord) iordc++;
        if (pc_en) begin pcen++; if (!ir_write) pcsrc = pc_source; end
        if (ir_write) irw++;
        if (alu_src_a && alu_src_b == 2'd0) aluc = alu_ctl;
        if (retired || illegal) begin
          chk("ret_ill_exclusive", retired & illegal, 0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL event_underflow actual=event expected=none at %0t", $time);
          end else begin
            e = rec_t'(exp_q.pop_front());
            chk("illegal", illegal, e.ill);
            chk("cycles", cyc, e.cyc);
            chk("reg_write_cnt", rw, e.rw);
            chk("reg_dst", rdst, e.rdst);
            chk("mem_to_reg", m2r, e.m2r);
            chk("mem_write_cnt", mwc, e.mwc);
            chk("mem_read_cnt", mrc, e.mrc);
            chk("iord_cnt", iordc, e.iordc);
            chk("pc_en_cnt", pcen, e.pcen);
            chk("pc_source", pcsrc, e.pcsrc);
            chk("ir_write_cnt", irw, e.irw);
            chk("alu_ctl", aluc, e.aluc);
          end
          cyc = 0; rw = 0; rdst = 0; m2r = 0; mwc = 0; mrc = 0;
          iordc = 0; pcen = 0; pcsrc = 0; irw = 0; aluc = 15;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] legal_fns [5];
    logic [5:0] op, fn;
    int         sel;
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    legal_fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    @(negedge clk);
    chk_strobes_zero("rst1");
    @(negedge clk);
    chk_strobes_zero("rst2");
    #1 reset = 1'b1;

    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h3F, 6'h20, 1'b0, 0, 0);
    run_instr(6'h00, 6'h03, 1'b0, 0, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 1, 2);
    run_instr(6'h08, 6'h00, 1'b0, 2, 0);
    run_instr(6'h02, 6'h00, 1'b1, 0, 0);
    run_instr(6'h00, 6'h2A, 1'b0, 1, 0);

    // sw abandoned by reset while waiting in MEM_WR.
    st_q.push_back(4'd0); st_q.push_back(4'd1);
    st_q.push_back(4'd2); st_q.push_back(4'd5);
    drive_cycle(6'h2B, 6'h00, 1'b0, 1'b1);
    drive_cycle(6'h2B, 6'h00, 1'b0, coin());
    drive_cycle(6'h2B, 6'h00, 1'b0, coin());
    drive_cycle(6'h2B, 6'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_mem_write_before", mem_write, 1);
    #1 reset = 1'b0;
    #1;
    chk("midrst_state", dbg_state, 0);
    chk_strobes_zero("midrst");
    @(negedge clk);
    chk("midrst_state_held", dbg_state, 0);
    #1 reset = 1'b1;

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      fn  = legal_fns[$urandom_range(0, 4)];
      if (sel < 6) op = legal_ops[sel];
      else if (sel == 6) op = 6'($urandom_range(0, 63));
      else begin op = 6'h00; fn = 6'($urandom_range(0, 63)); end
      run_instr(op, fn, coin(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(negedge clk);
    #1 mon_en = 1'b0;
    chk("exp_q_left", exp_q.size(), 0);
    chk("st_q_left", st_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
